simon_seq_sched: RTL and testbench
==================================

Name: simon_seq_sched

Overview:
Scheduler that owns the Simon pattern memory port and sequences every access to it. It serves three kinds of request: store an input pattern, paced playback of the stored sequence to the LEDs, and verify a repeat guess against the stored sequence. It sits between the Simon mode controller and an external synchronous single-port pattern RAM. It replaces ad-hoc index/increment handling with explicit, timed memory transactions.

Parameters:
ADDR_W, 5, memory address width; capacity DEPTH = 2**ADDR_W patterns
PAT_W, 4, pattern width (one bit per LED)
HOLD_CYCLES, 4, cycles each played entry is shown (>=1)
BLANK_CYCLES, 1, dark cycles between played entries (>=1)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous reset, active-high
pattern_in  in  PAT_W  switch pattern, sampled on the cycle a store/guess request is accepted
store_req  in  1  append pattern_in to the sequence
play_req  in  1  play back the entire stored sequence
guess_req  in  1  compare pattern_in with the next expected entry
clear_req  in  1  empty the sequence and abort any operation
mem_addr  out  ADDR_W  RAM address
mem_we  out  1  RAM write enable
mem_wdata  out  PAT_W  RAM write data
mem_rdata  in  PAT_W  RAM read data, valid the cycle after mem_addr is presented with mem_we=0
busy  out  1  high whenever state != IDLE
led_pattern  out  PAT_W  pattern shown during playback
led_valid  out  1  high during HOLD cycles
seq_len  out  ADDR_W+1  number of stored patterns
full  out  1  seq_len == DEPTH
play_done  out  1  one-cycle pulse
guess_ok  out  1  one-cycle pulse
guess_bad  out  1  one-cycle pulse
round_done  out  1  one-cycle pulse when the whole sequence has been guessed correctly

Behaviour:
- Reset (asynchronous): state=IDLE; seq_len=0; play index pi=0; guess index gi=0; all outputs 0. Reset asserted mid-operation aborts it immediately.
- States: IDLE, STORE, P_FETCH, P_HOLD, P_BLANK, G_FETCH, G_CMP.
- Requests are sampled only in IDLE. Priority is clear > store > play > guess. Requests other than clear are ignored while busy.
- clear_req, in any state: the next state is IDLE; seq_len, gi, pi = 0; mem_we=0; led_valid=0; no pulses.
- store in IDLE with full=1: ignored, and the block stays in IDLE. Otherwise:
  - pattern_in is latched and the block enters STORE for exactly 1 cycle with mem_we=1, mem_addr=seq_len, mem_wdata=latched pattern.
  - seq_len increments at the end of that cycle.
  - gi is cleared (a new round starts).
- play in IDLE with seq_len==0: play_done pulses the next cycle and the block stays in IDLE; no LED output.
- play in IDLE with seq_len>0: pi=0 and gi=0, then per entry:
  - P_FETCH, 1 cycle: mem_addr=pi.
  - P_HOLD, HOLD_CYCLES cycles: led_pattern = mem_rdata captured on entry and held stable; led_valid=1.
  - P_BLANK, BLANK_CYCLES cycles: led_valid=0; led_pattern keeps its last value.
  - At the end of BLANK, pi increments. If the entry just finished was entry seq_len-1, play_done pulses on the last BLANK cycle, then IDLE with pi=0.
  - Each entry therefore takes 1+HOLD_CYCLES+BLANK_CYCLES cycles.
- guess in IDLE:
  - With seq_len==0: guess_bad pulses the next cycle and the block stays in IDLE.
  - Otherwise pattern_in is latched, then G_FETCH (mem_addr=gi, 1 cycle), then G_CMP (1 cycle) compares the latched value with mem_rdata.
  - Match: guess_ok=1 and gi increments. If the new gi==seq_len, round_done=1 in the same cycle and gi=0.
  - Mismatch: guess_bad=1 and gi=0.
  - The block returns to IDLE after G_CMP, so each guess takes 2 cycles.
- mem_we is high only in STORE. mem_addr is 0 in IDLE.
- seq_len saturates at DEPTH and never wraps. full is combinational from seq_len.
- Pulses never overlap, except that round_done coincides with guess_ok.

Test Plan:
- Reset then idle: with rst high mid-playback, all outputs are 0 immediately, busy=0, seq_len=0.
- Store 4'b0011 then 4'b1000: mem_we is high one cycle at addr 0 with data 3, then one cycle at addr 1 with data 8. seq_len=2 and busy is high for 1 cycle per store.
- Play with seq_len=2 and defaults: led_valid is high for 4 cycles showing 3, low for 1, high for 4 showing 8. play_done pulses on cycle 12 after acceptance (two entries of 6 cycles each); led_valid never shows a third entry.
- Guess 3 then 8 with seq_len=2: guess_ok pulses twice, and round_done coincides with the second guess_ok. Guessing 3 then 5 instead gives guess_ok then guess_bad, and gi returns to 0.
- Boundaries:
  - Fill to 32 entries with ADDR_W=5: full=1, and a 33rd store produces no mem_we with seq_len held at 32.
  - play or guess with seq_len=0 pulses play_done or guess_bad, respectively, in 1 cycle.
- Simultaneous and abort cases:
  - store_req+play_req in the same IDLE cycle: the store is served and the play is dropped.
  - clear_req during P_HOLD: led_valid drops next cycle, no play_done, seq_len=0.

Source files
------------

// File: rtl/simon_seq_sched.sv
// Simon pattern-memory scheduler: owns the single RAM port for store, paced playback and guess checking.
// Latency: store 1 cycle after accept; guess result 2 cycles after accept; playback 1+HOLD+BLANK cycles per entry.
// Backpressure: requests are sampled only while idle and dropped when busy; clear_req aborts any operation.
//
// Ports:
//   clk, rst              rising-edge clock, asynchronous active-high reset
//   pattern_in            switch pattern, latched when a store/guess is accepted
//   store_req/play_req/guess_req/clear_req   operation requests (priority clear > store > play > guess)
//   mem_addr/mem_we/mem_wdata/mem_rdata      synchronous single-port RAM, read data one cycle after address
//   busy                  operation in progress
//   led_pattern/led_valid playback output, valid during the hold window
//   seq_len/full          stored sequence length and capacity flag
//   play_done/guess_ok/guess_bad/round_done  one-cycle result pulses
module simon_seq_sched #(
  parameter int ADDR_W       = 5,
  parameter int PAT_W        = 4,
  parameter int HOLD_CYCLES  = 4,
  parameter int BLANK_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [PAT_W-1:0]  pattern_in,
  input  logic              store_req,
  input  logic              play_req,
  input  logic              guess_req,
  input  logic              clear_req,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [PAT_W-1:0]  mem_wdata,
  input  logic [PAT_W-1:0]  mem_rdata,
  output logic              busy,
  output logic [PAT_W-1:0]  led_pattern,
  output logic              led_valid,
  output logic [ADDR_W:0]   seq_len,
  output logic              full,
  output logic              play_done,
  output logic              guess_ok,
  output logic              guess_bad,
  output logic              round_done
);

  localparam int CNT_MAX = (HOLD_CYCLES > BLANK_CYCLES) ? HOLD_CYCLES : BLANK_CYCLES;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE, STORE, P_FETCH, P_HOLD, P_BLANK, G_FETCH, G_CMP
  } state_t;

  state_t             state, state_nxt;
  logic [ADDR_W-1:0]  pi, gi;
  logic [CNT_W-1:0]   cnt;
  logic [PAT_W-1:0]   lat_pat;
  logic [PAT_W-1:0]   led_reg;
  logic               play_empty_q, guess_empty_q;

  logic               pi_last;
  logic [ADDR_W:0]    gi_inc;
  logic               match;
  logic               round_hit;

  assign full      = seq_len[ADDR_W];
  assign pi_last   = ({1'b0, pi} == (seq_len - 1'b1));
  assign gi_inc    = {1'b0, gi} + 1'b1;
  assign match     = (lat_pat == mem_rdata);
  assign round_hit = (gi_inc == seq_len);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (store_req)      state_nxt = full ? IDLE : STORE;
        else if (play_req)  state_nxt = (seq_len == '0) ? IDLE : P_FETCH;
        else if (guess_req) state_nxt = (seq_len == '0) ? IDLE : G_FETCH;
      end
      STORE:   state_nxt = IDLE;
      P_FETCH: state_nxt = P_HOLD;
      P_HOLD:  if (cnt == HOLD_LAST) state_nxt = P_BLANK;
      P_BLANK: if (cnt == BLANK_LAST) state_nxt = pi_last ? IDLE : P_FETCH;
      G_FETCH: state_nxt = G_CMP;
      G_CMP:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (clear_req) state_nxt = IDLE;
  end

  // Datapath: sequence length, indices, latches and the hold/blank timer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seq_len       <= '0;
      pi            <= '0;
      gi            <= '0;
      cnt           <= '0;
      lat_pat       <= '0;
      led_reg       <= '0;
      play_empty_q  <= 1'b0;
      guess_empty_q <= 1'b0;
    end else begin
      play_empty_q  <= 1'b0;
      guess_empty_q <= 1'b0;
      // Timer restarts on every state change so each window counts from zero.
      cnt <= (state_nxt != state) ? '0 : cnt + 1'b1;
      if (clear_req) begin
        seq_len <= '0;
        pi      <= '0;
        gi      <= '0;
      end else begin
        unique case (state)
          IDLE: begin
            if (store_req) begin
              if (!full) begin
                lat_pat <= pattern_in;
                gi      <= '0;
              end
            end else if (play_req) begin
              if (seq_len == '0) play_empty_q <= 1'b1;
              else begin
                pi <= '0;
                gi <= '0;
              end
            end else if (guess_req) begin
              if (seq_len == '0) guess_empty_q <= 1'b1;
              else               lat_pat <= pattern_in;
            end
          end
          STORE: if (!full) seq_len <= seq_len + 1'b1;
          // Read data is only valid in the first hold cycle; keep a copy for the rest.
          P_HOLD: if (cnt == '0) led_reg <= mem_rdata;
          P_BLANK: if (cnt == BLANK_LAST) pi <= pi_last ? '0 : pi + 1'b1;
          G_CMP: begin
            if (match) gi <= round_hit ? '0 : gi_inc[ADDR_W-1:0];
            else       gi <= '0;
          end
          default: ;
        endcase
      end
    end
  end

  // Outputs
  always_comb begin
    mem_addr    = '0;
    mem_we      = 1'b0;
    mem_wdata   = '0;
    busy        = (state != IDLE);
    led_valid   = (state == P_HOLD);
    led_pattern = led_reg;
    play_done   = 1'b0;
    guess_ok    = 1'b0;
    guess_bad   = 1'b0;
    round_done  = 1'b0;
    unique case (state)
      STORE: begin
        mem_addr  = seq_len[ADDR_W-1:0];
        mem_we    = 1'b1;
        mem_wdata = lat_pat;
      end
      P_FETCH: mem_addr = pi;
      P_HOLD:  if (cnt == '0) led_pattern = mem_rdata;
      P_BLANK: play_done = (cnt == BLANK_LAST) && pi_last;
      G_FETCH: mem_addr = gi;
      G_CMP: begin
        guess_ok   = match;
        guess_bad  = !match;
        round_done = match && round_hit;
      end
      default: ;
    endcase
    if (play_empty_q)  play_done = 1'b1;
    if (guess_empty_q) guess_bad = 1'b1;
    // An aborted operation reports no result.
    if (clear_req) begin
      play_done  = 1'b0;
      guess_ok   = 1'b0;
      guess_bad  = 1'b0;
      round_done = 1'b0;
    end
  end

endmodule

// File: tb/tb_simon_seq_sched.sv
module tb_simon_seq_sched;
  localparam int ADDR_W = 5;
  localparam int PAT_W  = 4;
  localparam int DEPTH  = 32;

  logic              clk = 1'b0;
  logic              rst;
  logic [PAT_W-1:0]  pattern_in;
  logic              store_req, play_req, guess_req, clear_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [PAT_W-1:0]  mem_wdata;
  logic [PAT_W-1:0]  mem_rdata;
  logic              busy;
  logic [PAT_W-1:0]  led_pattern;
  logic              led_valid;
  logic [ADDR_W:0]   seq_len;
  logic              full, play_done, guess_ok, guess_bad, round_done;

  simon_seq_sched #(.ADDR_W(ADDR_W), .PAT_W(PAT_W), .HOLD_CYCLES(4), .BLANK_CYCLES(1)) dut (
    .clk(clk), .rst(rst), .pattern_in(pattern_in),
    .store_req(store_req), .play_req(play_req), .guess_req(guess_req), .clear_req(clear_req),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .busy(busy), .led_pattern(led_pattern), .led_valid(led_valid),
    .seq_len(seq_len), .full(full), .play_done(play_done),
    .guess_ok(guess_ok), .guess_bad(guess_bad), .round_done(round_done)
  );

  always #5 clk = ~clk;

  // External synchronous single-port pattern RAM
  logic [PAT_W-1:0] ram [DEPTH];
  initial for (int i = 0; i < DEPTH; i++) ram[i] = '0;
  initial mem_rdata = '0;
  always @(posedge clk) begin
    if (mem_we) ram[mem_addr] <= mem_wdata;
    mem_rdata <= ram[mem_addr];
  end

  // Reference model: the stored sequence and the next expected guess position
  logic [PAT_W-1:0] ref_q[$];
  int ref_gi;
  int total = 0;
  int bad   = 0;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task tick();
    @(posedge clk);
    #2;
  endtask

  task test_reset();
    #1;
    total++;
    if ({busy, mem_we, led_valid, full} !== 4'b0) begin
      bad++; $display("FAIL reset_flags got=%b want=0000", {busy, mem_we, led_valid, full});
    end
    total++;
    if (seq_len !== '0 || mem_addr !== '0 || led_pattern !== '0 || mem_wdata !== '0) begin
      bad++; $display("FAIL reset_values got=%0h/%0h/%0h/%0h want=0", seq_len, mem_addr, led_pattern, mem_wdata);
    end
    total++;
    if ({play_done, guess_ok, guess_bad, round_done} !== 4'b0) begin
      bad++; $display("FAIL reset_pulses got=%b want=0000", {play_done, guess_ok, guess_bad, round_done});
    end
  endtask

  task do_store(input logic [PAT_W-1:0] p);
    int  n;
    bit  accept;
    n = ref_q.size();
    accept = (n < DEPTH);
    pattern_in = p;
    store_req  = 1'b1;
    tick();
    store_req  = 1'b0;
    pattern_in = PAT_W'($urandom_range(0, 15));
    #1;
    total++;
    if (accept) begin
      if ({mem_we, busy, mem_addr, mem_wdata} !== {1'b1, 1'b1, ADDR_W'(n), p}) begin
        bad++; $display("FAIL store_write got=%0h want=%0h", {mem_we, busy, mem_addr, mem_wdata}, {1'b1, 1'b1, ADDR_W'(n), p});
      end
      ref_q.push_back(p);
      ref_gi = 0;
    end else begin
      if ({mem_we, busy} !== 2'b00) begin
        bad++; $display("FAIL store_full_ignored got=%b want=00", {mem_we, busy});
      end
    end
    tick();
    #1;
    total++;
    if ({busy, mem_we} !== 2'b00 || seq_len !== (ADDR_W+1)'(ref_q.size())) begin
      bad++; $display("FAIL store_after got=%b/%0d want=00/%0d", {busy, mem_we}, seq_len, ref_q.size());
    end
  endtask

  task do_guess(input logic [PAT_W-1:0] p);
    int   n;
    logic exp_ok, exp_rd;
    n = ref_q.size();
    pattern_in = p;
    guess_req  = 1'b1;
    tick();
    guess_req  = 1'b0;
    pattern_in = PAT_W'($urandom_range(0, 15));
    #1;
    if (n == 0) begin
      total++;
      if ({guess_bad, guess_ok, round_done, busy} !== 4'b1000) begin
        bad++; $display("FAIL guess_empty got=%b want=1000", {guess_bad, guess_ok, round_done, busy});
      end
      tick();
      #1;
      total++;
      if (guess_bad !== 1'b0) begin
        bad++; $display("FAIL guess_empty_pulse_len got=%b want=0", guess_bad);
      end
    end else begin
      total++;
      if (busy !== 1'b1 || mem_addr !== ADDR_W'(ref_gi)) begin
        bad++; $display("FAIL guess_fetch got=%b/%0d want=1/%0d", busy, mem_addr, ref_gi);
      end
      tick();
      #1;
      exp_ok = (p == ref_q[ref_gi]);
      exp_rd = 1'b0;
      if (exp_ok) begin
        ref_gi++;
        if (ref_gi == n) begin
          exp_rd = 1'b1;
          ref_gi = 0;
        end
      end else begin
        ref_gi = 0;
      end
      total++;
      if ({guess_ok, guess_bad, round_done} !== {exp_ok, !exp_ok, exp_rd}) begin
        bad++; $display("FAIL guess_result got=%b want=%b", {guess_ok, guess_bad, round_done}, {exp_ok, !exp_ok, exp_rd});
      end
      tick();
      #1;
      total++;
      if ({busy, guess_ok, guess_bad, round_done} !== 4'b0) begin
        bad++; $display("FAIL guess_after got=%b want=0000", {busy, guess_ok, guess_bad, round_done});
      end
    end
  endtask

  task run_play();
    int n;
    bit exp_valid, exp_done;
    n = ref_q.size();
    play_req = 1'b1;
    tick();
    play_req = 1'b0;
    ref_gi = 0;
    for (int k = 0; k < n; k++) begin
      for (int c = 0; c < 6; c++) begin
        #1;
        exp_valid = (c >= 1 && c <= 4);
        exp_done  = (k == n - 1) && (c == 5);
        total++;
        if (led_valid !== exp_valid || play_done !== exp_done || busy !== 1'b1) begin
          bad++; $display("FAIL play_timing entry=%0d cyc=%0d got=%b want=%b", k, c, {led_valid, play_done, busy}, {exp_valid, exp_done, 1'b1});
        end
        if (exp_valid) begin
          total++;
          if (led_pattern !== ref_q[k]) begin
            bad++; $display("FAIL play_pattern entry=%0d cyc=%0d got=%0h want=%0h", k, c, led_pattern, ref_q[k]);
          end
        end
        if (c == 0) begin
          total++;
          if (mem_addr !== ADDR_W'(k)) begin
            bad++; $display("FAIL play_addr got=%0d want=%0d", mem_addr, k);
          end
        end
        tick();
      end
    end
    #1;
    total++;
    if ({busy, led_valid, play_done} !== 3'b000) begin
      bad++; $display("FAIL play_end got=%b want=000", {busy, led_valid, play_done});
    end
  endtask

  task do_clear();
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    #1;
    total++;
    if ({busy, full, led_valid} !== 3'b000 || seq_len !== '0) begin
      bad++; $display("FAIL clear got=%b/%0d want=000/0", {busy, full, led_valid}, seq_len);
    end
    ref_q.delete();
    ref_gi = 0;
  endtask

  task test_store();
    do_store(4'b0011);
    do_store(4'b1000);
    total++;
    if (seq_len !== 6'd2) begin
      bad++; $display("FAIL store_len got=%0d want=2", seq_len);
    end
  endtask

  task test_play();
    run_play();
  endtask

  task test_guess();
    do_guess(4'd3);
    do_guess(4'd8);
    do_guess(4'd3);
    do_guess(4'd5);
    do_guess(4'd3);
    do_guess(4'd8);
  endtask

  task test_reset_mid_play();
    play_req = 1'b1;
    tick();
    play_req = 1'b0;
    tick();
    tick();
    #1;
    total++;
    if (led_valid !== 1'b1) begin
      bad++; $display("FAIL midplay_precondition got=%b want=1", led_valid);
    end
    rst = 1'b1;
    #1;
    total++;
    if ({busy, led_valid, mem_we, play_done} !== 4'b0 || seq_len !== '0 || led_pattern !== '0 || mem_addr !== '0) begin
      bad++; $display("FAIL midplay_reset got=%b/%0d/%0h/%0d want=0", {busy, led_valid, mem_we, play_done}, seq_len, led_pattern, mem_addr);
    end
    #3;
    rst = 1'b0;
    ref_q.delete();
    ref_gi = 0;
  endtask

  task test_empty();
    play_req = 1'b1;
    tick();
    play_req = 1'b0;
    #1;
    total++;
    if ({play_done, busy, led_valid} !== 3'b100) begin
      bad++; $display("FAIL play_empty got=%b want=100", {play_done, busy, led_valid});
    end
    tick();
    #1;
    total++;
    if (play_done !== 1'b0) begin
      bad++; $display("FAIL play_empty_pulse_len got=%b want=0", play_done);
    end
    do_guess(4'd7);
  endtask

  task test_simul();
    pattern_in = 4'hA;
    store_req  = 1'b1;
    play_req   = 1'b1;
    tick();
    store_req  = 1'b0;
    play_req   = 1'b0;
    #1;
    total++;
    if ({mem_we, mem_addr, mem_wdata} !== {1'b1, 5'd0, 4'hA}) begin
      bad++; $display("FAIL simul_store got=%0h want=%0h", {mem_we, mem_addr, mem_wdata}, {1'b1, 5'd0, 4'hA});
    end
    ref_q.push_back(4'hA);
    ref_gi = 0;
    tick();
    for (int i = 0; i < 8; i++) begin
      #1;
      total++;
      if ({busy, led_valid, play_done} !== 3'b000) begin
        bad++; $display("FAIL simul_play_dropped cyc=%0d got=%b want=000", i, {busy, led_valid, play_done});
      end
      tick();
    end
    total++;
    if (seq_len !== 6'd1) begin
      bad++; $display("FAIL simul_len got=%0d want=1", seq_len);
    end
  endtask

  task test_clear_hold();
    play_req = 1'b1;
    tick();
    play_req = 1'b0;
    tick();
    #1;
    total++;
    if (led_valid !== 1'b1) begin
      bad++; $display("FAIL clear_hold_precondition got=%b want=1", led_valid);
    end
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    ref_q.delete();
    ref_gi = 0;
    for (int i = 0; i < 8; i++) begin
      #1;
      total++;
      if ({led_valid, busy, play_done} !== 3'b000 || seq_len !== '0) begin
        bad++; $display("FAIL clear_hold cyc=%0d got=%b/%0d want=000/0", i, {led_valid, busy, play_done}, seq_len);
      end
      tick();
    end
  endtask

  task test_fill();
    do_clear();
    for (int i = 0; i < DEPTH; i++) begin
      total++;
      if (full !== 1'b0) begin
        bad++; $display("FAIL fill_early_full at=%0d got=%b want=0", i, full);
      end
      do_store(PAT_W'($urandom_range(0, 15)));
    end
    total++;
    if (full !== 1'b1 || seq_len !== 6'd32) begin
      bad++; $display("FAIL fill_full got=%b/%0d want=1/32", full, seq_len);
    end
    do_store(4'd5);
    run_play();
    for (int i = 0; i < DEPTH; i++) do_guess(ref_q[ref_gi]);
  endtask

  task test_random();
    int op;
    do_clear();
    for (int it = 0; it < 60; it++) begin
      op = $urandom_range(0, 9);
      if (op <= 3) begin
        do_store(PAT_W'($urandom_range(0, 15)));
      end else if (op <= 7) begin
        if (ref_q.size() > 0 && $urandom_range(0, 9) < 7) do_guess(ref_q[ref_gi]);
        else do_guess(PAT_W'($urandom_range(0, 15)));
      end else if (op == 8) begin
        if (ref_q.size() > 0 && ref_q.size() <= 12) run_play();
      end else begin
        if ($urandom_range(0, 3) == 0) do_clear();
      end
    end
  endtask

  initial begin
    rst        = 1'b1;
    pattern_in = '0;
    store_req  = 1'b0;
    play_req   = 1'b0;
    guess_req  = 1'b0;
    clear_req  = 1'b0;
    ref_gi     = 0;
    test_reset();
    #12;
    rst = 1'b0;
    test_store();
    test_play();
    test_guess();
    test_reset_mid_play();
    test_empty();
    test_simul();
    test_clear_hold();
    test_fill();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
